// File: rtl/board_state_reg_if.sv
// Move-request / board-status bundle between the game controller and board_state_reg.
// The undo strobe exists only when BOARD_UNDO_EN is defined.
interface board_state_reg_if #(
   parameter int SIZE = 3
);
   localparam int CELLS = SIZE * SIZE;
   localparam int IDXW  = $clog2(CELLS);
   localparam int CNTW  = $clog2(CELLS + 1);

   logic                 mv_valid;
   logic [IDXW-1:0]      mv_idx;
   logic                 mv_player;
`ifdef BOARD_UNDO_EN
   logic                 undo;
`endif
   logic [2*CELLS-1:0]   board;
   logic                 turn;
   logic [CNTW-1:0]      move_cnt;
   logic                 full;
   logic                 ack;
   logic                 ill;

   modport master (
      output mv_valid, mv_idx, mv_player,
`ifdef BOARD_UNDO_EN
      undo,
`endif
      input  board, turn, move_cnt, full, ack, ill
   );

   modport slave (
      input  mv_valid, mv_idx, mv_player,
`ifdef BOARD_UNDO_EN
      undo,
`endif
      output board, turn, move_cnt, full, ack, ill
   );
endinterface

// File: rtl/board_state_reg.sv
// board_state_reg: SIZE x SIZE game-board register with move validation, turn tracking and move count.
// Defining BOARD_UNDO_EN adds a one-deep take-back of the last committed move.
module board_state_reg #(
   parameter int SIZE         = 3,
   parameter bit FIRST_PLAYER = 1'b0
) (
   input logic               clk,
   input logic               rst,
   input logic               clr,
   board_state_reg_if.slave  bus
);
   localparam int CELLS = SIZE * SIZE;
   localparam int IDXW  = $clog2(CELLS);
   localparam int CNTW  = $clog2(CELLS + 1);
   localparam logic [IDXW:0]   CELLS_IDX = (IDXW + 1)'(CELLS);
   localparam logic [CNTW-1:0] CELLS_CNT = CNTW'(CELLS);

   logic [2*CELLS-1:0] board_q;
   logic               turn_q;
   logic [CNTW-1:0]    cnt_q;
   logic               full_q;
   logic               ack_q;
   logic               ill_q;

   logic [1:0]         target_cell;
   logic [1:0]         player_code;
   logic               in_range;
   logic               mv_legal;

`ifdef BOARD_UNDO_EN
   logic               hist_valid;
   logic [IDXW-1:0]    hist_idx;
`endif

   // Out-of-range indices never match a cell, so they read as empty and are rejected by in_range.
   always_comb begin
      target_cell = 2'b00;
      for (int k = 0; k < CELLS; k++) begin
         if (bus.mv_idx == IDXW'(k)) begin
            target_cell = board_q[2*k +: 2];
         end
      end
   end

   always_comb begin
      in_range    = ({1'b0, bus.mv_idx} < CELLS_IDX);
      player_code = bus.mv_player ? 2'b10 : 2'b01;
      mv_legal    = in_range && (target_cell == 2'b00) &&
                    (bus.mv_player == turn_q) && !full_q;
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         board_q <= '0;
         turn_q  <= FIRST_PLAYER;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         ack_q   <= 1'b0;
         ill_q   <= 1'b0;
`ifdef BOARD_UNDO_EN
         hist_valid <= 1'b0;
         hist_idx   <= '0;
`endif
      end else begin
         ack_q <= 1'b0;
         ill_q <= 1'b0;
`ifdef BOARD_UNDO_EN
         // Undo outranks a simultaneous move; the move is dropped silently.
         if (bus.undo) begin
            if (hist_valid) begin
               for (int k = 0; k < CELLS; k++) begin
                  if (hist_idx == IDXW'(k)) begin
                     board_q[2*k +: 2] <= 2'b00;
                  end
               end
               cnt_q      <= cnt_q - CNTW'(1);
               turn_q     <= ~turn_q;
               full_q     <= 1'b0;
               ack_q      <= 1'b1;
               hist_valid <= 1'b0;
            end else begin
               ill_q <= 1'b1;
            end
         end else
`endif
         if (bus.mv_valid) begin
            if (mv_legal) begin
               for (int k = 0; k < CELLS; k++) begin
                  if (bus.mv_idx == IDXW'(k)) begin
                     board_q[2*k +: 2] <= player_code;
                  end
               end
               cnt_q  <= cnt_q + CNTW'(1);
               full_q <= ((cnt_q + CNTW'(1)) == CELLS_CNT);
               turn_q <= ~turn_q;
               ack_q  <= 1'b1;
`ifdef BOARD_UNDO_EN
               hist_valid <= 1'b1;
               hist_idx   <= bus.mv_idx;
`endif
            end else begin
               ill_q <= 1'b1;
            end
         end
      end
   end

   assign bus.board    = board_q;
   assign bus.turn     = turn_q;
   assign bus.move_cnt = cnt_q;
   assign bus.full     = full_q;
   assign bus.ack      = ack_q;
   assign bus.ill      = ill_q;

endmodule

// File: doc/board_state_reg.md
# board_state_reg

Parametrised N×N game-board state register with move validation, turn tracking and move counting. It generalises the fixed 3×3 position register. It accepts one move request per cycle, rejects illegal moves with a pulse instead of silently holding, and exposes the packed board to the win-detect and display logic.

## Interface
- SIZE, 3, board edge length (3..5); CELLS = SIZE*SIZE, IDXW = clog2(CELLS), CNTW = clog2(CELLS+1) derived.
- FIRST_PLAYER, 0, player to move after reset/clear (0 = X, 1 = O).

- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous board clear, same effect as rst.
- mv_valid  in  1  move request strobe, sampled every clk.
- mv_idx  in  IDXW  target cell, row-major, cell 0 = top-left.
- mv_player  in  1  requesting player (0 = X, 1 = O).
- undo  in  1  take back last move (present only with BOARD_UNDO_EN).
- board  out  2*CELLS  cell k at [2k+1:2k]: 00 empty, 01 X, 10 O; 11 never produced.
- turn  out  1  player expected next.
- move_cnt  out  CNTW  number of occupied cells.
- full  out  1  move_cnt == CELLS.
- ack  out  1  one-cycle pulse, move (or undo) committed.
- ill  out  1  one-cycle pulse, request rejected.

## Operation
- Reset/clr: board all 00, turn = FIRST_PLAYER, move_cnt = 0, full = 0, ack = 0, ill = 0, undo history invalid.
- Priority per cycle: rst > clr > undo > mv_valid. Lower-priority requests in the same cycle are dropped with no ack/ill.
- Move legal iff mv_idx < CELLS, the cell is 00, mv_player == turn, and full = 0.
- Legal move: the cell is written 01 (X) or 10 (O), move_cnt increments, turn toggles, and ack pulses. Last move is recorded as the history entry.
- Illegal move: board, turn and move_cnt are unchanged; ill pulses.
- Causes of an illegal move:
  - out-of-range index (for example idx ≥ 9 at SIZE=3);
  - occupied cell;
  - wrong player;
  - full board.
- No request: all state holds; ack = ill = 0.
- ack and ill are never high together.

## Timing
- Request sampled at edge T; board/turn/move_cnt/full updated and ack/ill asserted at edge T (visible T+1 cycle). ack/ill deassert at T+1 unless a new request arrives.
- Back-to-back moves every cycle supported; each is checked against the state updated by the previous edge.
- rst or clr asserted during any request: the request is discarded, reset values take effect the next cycle, and no ack/ill is produced.
- full rises in the same cycle move_cnt reaches CELLS.

## Configuration
- BOARD_UNDO_EN defined:
  - The undo port exists, with one-deep history.
  - undo with valid history: the recorded cell returns to 00, move_cnt decrements, turn toggles, ack pulses, and history becomes invalid.
  - undo with invalid history: ill pulses and state is unchanged.
  - undo with mv_valid in the same cycle: undo wins and the move is dropped.
- BOARD_UNDO_EN undefined: no undo port and no history storage; behaviour is otherwise identical.

## Test plan
- SIZE=3, rst then X idx 4 -> next cycle board[9:8]=01, turn=1, move_cnt=1, ack=1 for one cycle.
- After X at 4, O at idx 4 -> ill=1, board/turn unchanged. Then X at idx 0 (wrong player) -> ill=1. Then mv_idx=9 -> ill=1.
- Alternate legal moves on all 9 cells, one per cycle -> move_cnt 1..9, full=1 after the ninth move, and a tenth request gives ill=1.
- SIZE=4, FIRST_PLAYER=1: O at idx 15 -> board[31:30]=10, turn=0. clr with a simultaneous mv_valid -> board all 0, turn=1, no ack/ill.
- BOARD_UNDO_EN: X@2, O@5, undo -> board[11:10]=00, move_cnt=1, turn=1, ack. A second undo -> ill=1, state unchanged.
- rst asserted in the same cycle as a legal move -> the next cycle shows all outputs at reset values with ack=0.
